// File: rtl/avaliador_ativos_param.sv
// Active-node bank with relax/desativar commands and a sequential minimum-criterion scan.
// Optional build macro AVALIADOR_APROVADO_UNICO_EN: approve only the lowest-index tied slot.
module avaliador_ativos_param #(
    parameter int NUM_NA          = 8,
    parameter int ADDR_WIDTH      = 5,
    parameter int DISTANCIA_WIDTH = 5,
    parameter int CUSTO_WIDTH     = 4,
    parameter int CRITERIO_WIDTH  = DISTANCIA_WIDTH + 1,
    parameter int MODO_CRITERIO   = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cmd_valido_in,
    input  logic                            cmd_op_in,
    output logic                            cmd_pronto_out,
    input  logic [ADDR_WIDTH-1:0]           endereco_in,
    input  logic [DISTANCIA_WIDTH-1:0]      distancia_in,
    input  logic [CUSTO_WIDTH-1:0]          heuristica_in,
    input  logic [ADDR_WIDTH-1:0]           anterior_in,
    input  logic                            remover_aprovados_in,
    input  logic                            limpar_overflow_in,
    output logic [NUM_NA-1:0]               aa_aprovado_out,
    output logic [ADDR_WIDTH*NUM_NA-1:0]    aa_endereco_out,
    output logic [DISTANCIA_WIDTH*NUM_NA-1:0] aa_distancia_out,
    output logic [ADDR_WIDTH*NUM_NA-1:0]    aa_anterior_data_out,
    output logic [CRITERIO_WIDTH-1:0]       aa_criterio_min_out,
    output logic [$clog2(NUM_NA+1)-1:0]     aa_ocupacao_out,
    output logic                            aa_tem_ativo_out,
    output logic                            aa_tem_aprovado_out,
    output logic                            aa_pronto_out,
    output logic                            aa_overflow_out
);

    localparam int IDX_W   = $clog2(NUM_NA);
    localparam int OCUP_W  = $clog2(NUM_NA + 1);
    localparam int MAX_DC  = (DISTANCIA_WIDTH > CUSTO_WIDTH) ? DISTANCIA_WIDTH : CUSTO_WIDTH;
    localparam int MAX_ALL = (MAX_DC > CRITERIO_WIDTH) ? MAX_DC : CRITERIO_WIDTH;
    localparam int SOMA_W  = MAX_ALL + 1;

    typedef enum logic [1:0] {
        OCIOSO,
        BUSCA,
        CLASSIFICA,
        PRONTO
    } estado_t;

    estado_t estado_q, estado_d;

    logic [NUM_NA-1:0]          ativo_q, ativo_d;
    logic [ADDR_WIDTH-1:0]      endereco_q  [NUM_NA];
    logic [ADDR_WIDTH-1:0]      endereco_d  [NUM_NA];
    logic [DISTANCIA_WIDTH-1:0] distancia_q [NUM_NA];
    logic [DISTANCIA_WIDTH-1:0] distancia_d [NUM_NA];
    logic [ADDR_WIDTH-1:0]      anterior_q  [NUM_NA];
    logic [ADDR_WIDTH-1:0]      anterior_d  [NUM_NA];
    logic [CRITERIO_WIDTH-1:0]  criterio_q  [NUM_NA];
    logic [CRITERIO_WIDTH-1:0]  criterio_d  [NUM_NA];

    logic                       cmd_op_q, cmd_op_d;
    logic [ADDR_WIDTH-1:0]      cmd_end_q, cmd_end_d;
    logic [DISTANCIA_WIDTH-1:0] cmd_dist_q, cmd_dist_d;
    logic [CUSTO_WIDTH-1:0]     cmd_heur_q, cmd_heur_d;
    logic [ADDR_WIDTH-1:0]      cmd_ant_q, cmd_ant_d;

    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [CRITERIO_WIDTH-1:0]  min_q, min_d;
    logic [CRITERIO_WIDTH-1:0]  crit_min_q, crit_min_d;
    logic [NUM_NA-1:0]          aprovado_q, aprovado_d;
    logic                       pronto_q, pronto_d;
    logic                       overflow_q, overflow_d;

    logic                       aceita;
    logic [SOMA_W-1:0]          soma;
    logic [CRITERIO_WIDTH-1:0]  criterio_novo;
    logic                       achou, livre, overflow_set;
    logic [IDX_W-1:0]           idx_match, idx_livre;
    logic [CRITERIO_WIDTH-1:0]  min_prox;
    logic [NUM_NA-1:0]          empates, aprov_mask;
    logic [OCUP_W-1:0]          ocupacao;

    assign cmd_pronto_out = ((estado_q == OCIOSO) || (estado_q == PRONTO)) && !remover_aprovados_in;
    assign aceita         = cmd_valido_in && cmd_pronto_out;

    // Saturating criterion: anything beyond CRITERIO_WIDTH collapses to all ones.
    always_comb begin
        soma = SOMA_W'(cmd_dist_q);
        if (MODO_CRITERIO != 0) begin
            soma = soma + SOMA_W'(cmd_heur_q);
        end
        if (soma > SOMA_W'({CRITERIO_WIDTH{1'b1}})) begin
            criterio_novo = '1;
        end else begin
            criterio_novo = soma[CRITERIO_WIDTH-1:0];
        end
    end

    always_comb begin
        achou     = 1'b0;
        livre     = 1'b0;
        idx_match = '0;
        idx_livre = '0;
        for (int unsigned i = 0; i < NUM_NA; i++) begin
            if (!achou && ativo_q[i] && (endereco_q[i] == cmd_end_q)) begin
                achou     = 1'b1;
                idx_match = IDX_W'(i);
            end
            if (!livre && !ativo_q[i]) begin
                livre     = 1'b1;
                idx_livre = IDX_W'(i);
            end
        end
    end

    // Running minimum including the slot under the scan pointer this cycle.
    always_comb begin
        min_prox = min_q;
        if (ativo_q[idx_q] && (criterio_q[idx_q] < min_q)) begin
            min_prox = criterio_q[idx_q];
        end
        empates = '0;
        for (int unsigned i = 0; i < NUM_NA; i++) begin
            empates[i] = ativo_q[i] && (criterio_q[i] == min_prox);
        end
`ifdef AVALIADOR_APROVADO_UNICO_EN
        aprov_mask = empates & (~empates + NUM_NA'(1));
`else
        aprov_mask = empates;
`endif
    end

    always_comb begin
        estado_d     = estado_q;
        ativo_d      = ativo_q;
        endereco_d   = endereco_q;
        distancia_d  = distancia_q;
        anterior_d   = anterior_q;
        criterio_d   = criterio_q;
        cmd_op_d     = cmd_op_q;
        cmd_end_d    = cmd_end_q;
        cmd_dist_d   = cmd_dist_q;
        cmd_heur_d   = cmd_heur_q;
        cmd_ant_d    = cmd_ant_q;
        idx_d        = idx_q;
        min_d        = min_q;
        crit_min_d   = crit_min_q;
        aprovado_d   = aprovado_q;
        pronto_d     = pronto_q;
        overflow_set = 1'b0;

        case (estado_q)
            OCIOSO, PRONTO: begin
                if ((estado_q == PRONTO) && remover_aprovados_in) begin
                    ativo_d    = ativo_q & ~aprovado_q;
                    aprovado_d = '0;
                    pronto_d   = 1'b0;
                    idx_d      = '0;
                    min_d      = '1;
                    estado_d   = CLASSIFICA;
                end else if (aceita) begin
                    cmd_op_d   = cmd_op_in;
                    cmd_end_d  = endereco_in;
                    cmd_dist_d = distancia_in;
                    cmd_heur_d = heuristica_in;
                    cmd_ant_d  = anterior_in;
                    pronto_d   = 1'b0;
                    estado_d   = BUSCA;
                end
            end
            BUSCA: begin
                if (!cmd_op_q) begin
                    if (achou) begin
                        if (cmd_dist_q < distancia_q[idx_match]) begin
                            distancia_d[idx_match] = cmd_dist_q;
                            anterior_d[idx_match]  = cmd_ant_q;
                            criterio_d[idx_match]  = criterio_novo;
                        end
                    end else if (livre) begin
                        ativo_d[idx_livre]     = 1'b1;
                        endereco_d[idx_livre]  = cmd_end_q;
                        distancia_d[idx_livre] = cmd_dist_q;
                        anterior_d[idx_livre]  = cmd_ant_q;
                        criterio_d[idx_livre]  = criterio_novo;
                    end else begin
                        overflow_set = 1'b1;
                    end
                end else if (achou) begin
                    ativo_d[idx_match] = 1'b0;
                end
                idx_d    = '0;
                min_d    = '1;
                estado_d = CLASSIFICA;
            end
            CLASSIFICA: begin
                min_d = min_prox;
                if (idx_q == IDX_W'(NUM_NA - 1)) begin
                    crit_min_d = min_prox;
                    aprovado_d = aprov_mask;
                    pronto_d   = 1'b1;
                    estado_d   = PRONTO;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: estado_d = OCIOSO;
        endcase

        if (overflow_set) begin
            overflow_d = 1'b1;
        end else if (limpar_overflow_in) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q    <= OCIOSO;
            ativo_q     <= '0;
            endereco_q  <= '{default: '0};
            distancia_q <= '{default: '0};
            anterior_q  <= '{default: '0};
            criterio_q  <= '{default: '0};
            cmd_op_q    <= 1'b0;
            cmd_end_q   <= '0;
            cmd_dist_q  <= '0;
            cmd_heur_q  <= '0;
            cmd_ant_q   <= '0;
            idx_q       <= '0;
            min_q       <= '1;
            crit_min_q  <= '1;
            aprovado_q  <= '0;
            pronto_q    <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            ativo_q     <= ativo_d;
            endereco_q  <= endereco_d;
            distancia_q <= distancia_d;
            anterior_q  <= anterior_d;
            criterio_q  <= criterio_d;
            cmd_op_q    <= cmd_op_d;
            cmd_end_q   <= cmd_end_d;
            cmd_dist_q  <= cmd_dist_d;
            cmd_heur_q  <= cmd_heur_d;
            cmd_ant_q   <= cmd_ant_d;
            idx_q       <= idx_d;
            min_q       <= min_d;
            crit_min_q  <= crit_min_d;
            aprovado_q  <= aprovado_d;
            pronto_q    <= pronto_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        ocupacao             = '0;
        aa_endereco_out      = '0;
        aa_distancia_out     = '0;
        aa_anterior_data_out = '0;
        for (int unsigned i = 0; i < NUM_NA; i++) begin
            ocupacao = ocupacao + OCUP_W'(ativo_q[i]);
            aa_endereco_out[ADDR_WIDTH*i +: ADDR_WIDTH]           = endereco_q[i];
            aa_distancia_out[DISTANCIA_WIDTH*i +: DISTANCIA_WIDTH] = distancia_q[i];
            aa_anterior_data_out[ADDR_WIDTH*i +: ADDR_WIDTH]      = anterior_q[i];
        end
    end

    assign aa_aprovado_out     = aprovado_q;
    assign aa_criterio_min_out = crit_min_q;
    assign aa_ocupacao_out     = ocupacao;
    assign aa_tem_ativo_out    = |ativo_q;
    assign aa_tem_aprovado_out = |aprovado_q;
    assign aa_pronto_out       = pronto_q;
    assign aa_overflow_out     = overflow_q;

endmodule

// File: tb/tb_avaliador_ativos_param.sv
// Directed bench for avaliador_ativos_param at default parameters (NUM_NA=8, A* criterion).
module tb_avaliador_ativos_param;

    localparam int NA = 8;
    localparam int AW = 5;
    localparam int DW = 5;
    localparam int CW = 4;
    localparam int RW = DW + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valido_in = 1'b0;
    logic              cmd_op_in = 1'b0;
    logic              cmd_pronto_out;
    logic [AW-1:0]     endereco_in = '0;
    logic [DW-1:0]     distancia_in = '0;
    logic [CW-1:0]     heuristica_in = '0;
    logic [AW-1:0]     anterior_in = '0;
    logic              remover_aprovados_in = 1'b0;
    logic              limpar_overflow_in = 1'b0;
    logic [NA-1:0]     aa_aprovado_out;
    logic [AW*NA-1:0]  aa_endereco_out;
    logic [DW*NA-1:0]  aa_distancia_out;
    logic [AW*NA-1:0]  aa_anterior_data_out;
    logic [RW-1:0]     aa_criterio_min_out;
    logic [3:0]        aa_ocupacao_out;
    logic              aa_tem_ativo_out;
    logic              aa_tem_aprovado_out;
    logic              aa_pronto_out;
    logic              aa_overflow_out;

    int n_checks = 0;
    int n_errors = 0;

    avaliador_ativos_param #(
        .NUM_NA(NA), .ADDR_WIDTH(AW), .DISTANCIA_WIDTH(DW),
        .CUSTO_WIDTH(CW), .CRITERIO_WIDTH(RW), .MODO_CRITERIO(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valido_in(cmd_valido_in), .cmd_op_in(cmd_op_in), .cmd_pronto_out(cmd_pronto_out),
        .endereco_in(endereco_in), .distancia_in(distancia_in),
        .heuristica_in(heuristica_in), .anterior_in(anterior_in),
        .remover_aprovados_in(remover_aprovados_in), .limpar_overflow_in(limpar_overflow_in),
        .aa_aprovado_out(aa_aprovado_out), .aa_endereco_out(aa_endereco_out),
        .aa_distancia_out(aa_distancia_out), .aa_anterior_data_out(aa_anterior_data_out),
        .aa_criterio_min_out(aa_criterio_min_out), .aa_ocupacao_out(aa_ocupacao_out),
        .aa_tem_ativo_out(aa_tem_ativo_out), .aa_tem_aprovado_out(aa_tem_aprovado_out),
        .aa_pronto_out(aa_pronto_out), .aa_overflow_out(aa_overflow_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issue one command, then wait for the scan to finish and check its latency.
    task automatic do_cmd(input logic op, input logic [AW-1:0] e, input logic [DW-1:0] d,
                          input logic [CW-1:0] h, input logic [AW-1:0] a);
        int n;
        @(negedge clk);
        n = 0;
        while (!cmd_pronto_out && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("cmd_pronto_before", cmd_pronto_out, 1);
        cmd_valido_in = 1'b1;
        cmd_op_in     = op;
        endereco_in   = e;
        distancia_in  = d;
        heuristica_in = h;
        anterior_in   = a;
        @(posedge clk);
        #1;
        cmd_valido_in = 1'b0;
        check_eq("cmd_pronto_busy", cmd_pronto_out, 0);
        n = 0;
        while (!aa_pronto_out && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("latencia", n, 9);
    endtask

    initial begin
        int n;

        do_reset();
        #1;
        check_eq("rst_aprovado", aa_aprovado_out, 0);
        check_eq("rst_crit_min", aa_criterio_min_out, 6'h3F);
        check_eq("rst_ocupacao", aa_ocupacao_out, 0);
        check_eq("rst_tem_ativo", aa_tem_ativo_out, 0);
        check_eq("rst_tem_aprov", aa_tem_aprovado_out, 0);
        check_eq("rst_pronto", aa_pronto_out, 0);
        check_eq("rst_overflow", aa_overflow_out, 0);
        check_eq("rst_endereco", aa_endereco_out, 0);

        // Single insert: criterion 4+2=6
        do_cmd(1'b0, 5'd3, 5'd4, 4'd2, 5'd1);
        check_eq("s1_aprovado", aa_aprovado_out, 8'h01);
        check_eq("s1_crit_min", aa_criterio_min_out, 6);
        check_eq("s1_ocupacao", aa_ocupacao_out, 1);
        check_eq("s1_tem_aprov", aa_tem_aprovado_out, 1);
        check_eq("s1_end0", aa_endereco_out[AW*0 +: AW], 3);
        check_eq("s1_dist0", aa_distancia_out[DW*0 +: DW], 4);
        check_eq("s1_ant0", aa_anterior_data_out[AW*0 +: AW], 1);

        // Tie at criterion 4
        do_reset();
        do_cmd(1'b0, 5'd3, 5'd4, 4'd0, 5'd0);
        do_cmd(1'b0, 5'd5, 5'd2, 4'd2, 5'd0);
        check_eq("tie_crit_min", aa_criterio_min_out, 4);
        check_eq("tie_ocupacao", aa_ocupacao_out, 2);
`ifdef AVALIADOR_APROVADO_UNICO_EN
        check_eq("tie_aprovado", aa_aprovado_out, 8'h01);
`else
        check_eq("tie_aprovado", aa_aprovado_out, 8'h03);
`endif

        // Relax with larger distance: no change
        do_cmd(1'b0, 5'd3, 5'd6, 4'd0, 5'd2);
        check_eq("rlx_no_dist0", aa_distancia_out[DW*0 +: DW], 4);
        check_eq("rlx_no_ant0", aa_anterior_data_out[AW*0 +: AW], 0);
        check_eq("rlx_no_ocup", aa_ocupacao_out, 2);

        // Relax with smaller distance
        do_cmd(1'b0, 5'd3, 5'd1, 4'd0, 5'd7);
        check_eq("rlx_dist0", aa_distancia_out[DW*0 +: DW], 1);
        check_eq("rlx_ant0", aa_anterior_data_out[AW*0 +: AW], 7);
        check_eq("rlx_crit_min", aa_criterio_min_out, 1);
        check_eq("rlx_aprovado", aa_aprovado_out, 8'h01);

        // Deactivate address 3
        do_cmd(1'b1, 5'd3, 5'd0, 4'd0, 5'd0);
        check_eq("des_ocupacao", aa_ocupacao_out, 1);
        check_eq("des_crit_min", aa_criterio_min_out, 4);
        check_eq("des_aprovado", aa_aprovado_out, 8'h02);

        // Remover together with a command: remover wins
        @(negedge clk);
        remover_aprovados_in = 1'b1;
        cmd_valido_in = 1'b1;
        cmd_op_in     = 1'b0;
        endereco_in   = 5'd9;
        distancia_in  = 5'd1;
        heuristica_in = 4'd0;
        #1;
        check_eq("rem_cmd_pronto", cmd_pronto_out, 0);
        @(posedge clk);
        #1;
        remover_aprovados_in = 1'b0;
        cmd_valido_in = 1'b0;
        check_eq("rem_aprovado", aa_aprovado_out, 0);
        check_eq("rem_pronto", aa_pronto_out, 0);
        check_eq("rem_ocupacao", aa_ocupacao_out, 0);
        n = 0;
        while (!aa_pronto_out && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("rem_latencia", n, 8);
        check_eq("empty_aprovado", aa_aprovado_out, 0);
        check_eq("empty_crit_min", aa_criterio_min_out, 6'h3F);
        check_eq("empty_tem_ativo", aa_tem_ativo_out, 0);
        check_eq("empty_ocupacao", aa_ocupacao_out, 0);

        // Fill the bank, then overflow it
        do_reset();
        for (int i = 0; i < NA; i++) begin
            do_cmd(1'b0, AW'(i), DW'(i + 1), 4'd0, 5'd0);
        end
        check_eq("full_ocupacao", aa_ocupacao_out, 8);
        check_eq("full_overflow", aa_overflow_out, 0);
        do_cmd(1'b0, 5'd8, 5'd3, 4'd0, 5'd0);
        check_eq("ovf_flag", aa_overflow_out, 1);
        check_eq("ovf_ocupacao", aa_ocupacao_out, 8);
        check_eq("ovf_crit_min", aa_criterio_min_out, 1);
        check_eq("ovf_aprovado", aa_aprovado_out, 8'h01);
        check_eq("ovf_end7", aa_endereco_out[AW*7 +: AW], 7);
        @(negedge clk);
        limpar_overflow_in = 1'b1;
        @(posedge clk);
        #1;
        limpar_overflow_in = 1'b0;
        check_eq("ovf_clear", aa_overflow_out, 0);
        do_cmd(1'b0, 5'd20, 5'd1, 4'd0, 5'd0);
        check_eq("ovf_again", aa_overflow_out, 1);

        // Reset in the middle of a scan
        @(negedge clk);
        cmd_valido_in = 1'b1;
        cmd_op_in     = 1'b1;
        endereco_in   = 5'd0;
        @(posedge clk);
        #1;
        cmd_valido_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid_aprovado", aa_aprovado_out, 0);
        check_eq("mid_crit_min", aa_criterio_min_out, 6'h3F);
        check_eq("mid_pronto", aa_pronto_out, 0);
        check_eq("mid_overflow", aa_overflow_out, 0);
        check_eq("mid_ocupacao", aa_ocupacao_out, 0);
        check_eq("mid_tem_ativo", aa_tem_ativo_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("post_ocupacao", aa_ocupacao_out, 0);
        check_eq("post_pronto", aa_pronto_out, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
